// File: rtl/f1_start_sequencer_pkg.sv
// f1_pkg: shared types and constants for the F1 start-light sequencer.
// Related build macro: F1_RANDOM_DELAY_EN (enables the LFSR-driven hold delay).
package f1_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LIGHTS  = 2'd1,
        HOLD    = 2'd2,
        MEASURE = 2'd3
    } f1_state_t;

    localparam logic [7:0] LIGHTS_ALL = 8'hFF;

    localparam int              LFSR_W     = 7;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h01;
    // x^7 + x^6 + 1: feedback from the two most significant stages
    localparam int              LFSR_TAP_A = 6;
    localparam int              LFSR_TAP_B = 5;

    localparam int RT_W = 16;

    // One Fibonacci step; a non-zero state never maps to zero.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], q[LFSR_TAP_A] ^ q[LFSR_TAP_B]};
    endfunction

endpackage

// File: rtl/f1_start_sequencer_if.sv
// Handshake and display bundle between the sequencer and its parent top level.
interface f1_start_sequencer_if;
    import f1_pkg::*;

    logic            start;
    logic            react;
    logic [7:0]      out;
    logic            go;
    logic            busy;
    logic [RT_W-1:0] reaction_time;
    logic            time_valid;
    logic            false_start;

    modport master (
        output start, react,
        input  out, go, busy, reaction_time, time_valid, false_start
    );

    modport slave (
        input  start, react,
        output out, go, busy, reaction_time, time_valid, false_start
    );

endinterface

// File: rtl/f1_start_sequencer_tick_gen.sv
// f1_tick_gen: period counter producing one tick every N+1 enabled cycles.
// If N drops below the current count, the counter runs on and wraps through
// its full range before matching again.
module f1_tick_gen #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] N,
    output logic             tick
);

    logic [WIDTH-1:0] cnt;

    assign tick = en && !clr && (cnt == N);

    // Count 0..N on enabled cycles; synchronous clear holds it at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == N) cnt <= '0;
            else          cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/f1_start_sequencer.sv
// f1_start_sequencer: start-light sequence, hold delay, go pulse and reaction
// timing in one block. Build macro F1_RANDOM_DELAY_EN selects an LFSR-based
// hold delay of 1..16 ticks; otherwise the hold is FIXED_DELAY ticks.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | lights off, waiting for start
// LIGHTS  | one more light per tick until all eight are lit
// HOLD    | all lights lit, counting down the hold delay in ticks
// MEASURE | lights out, counting cycles until the driver reacts
module f1_start_sequencer
    import f1_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int FIXED_DELAY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] N,
    f1_start_sequencer_if.slave bus
);

    f1_state_t       state, state_nx;
    logic [7:0]      out_q, out_nx;
    logic            go_q, go_nx;
    logic            busy_q, busy_nx;
    logic [RT_W-1:0] rt_q, rt_nx;
    logic            tv_q, tv_nx;
    logic            fs_q, fs_nx;
    logic [4:0]      hold_q, hold_nx;
    logic [RT_W-1:0] rcnt_q, rcnt_nx;
    logic [4:0]      d_load;
    logic            seq_active;
    logic            tick;

    assign seq_active = (state == LIGHTS) || (state == HOLD);

    f1_tick_gen #(.WIDTH(WIDTH)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en && seq_active),
        .clr  (!seq_active),
        .N    (N),
        .tick (tick)
    );

`ifdef F1_RANDOM_DELAY_EN
    logic [LFSR_W-1:0] lfsr_q;

    // Free-running delay source; advances on every clock, enabled or not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= LFSR_SEED;
        else      lfsr_q <= lfsr_next(lfsr_q);
    end

    assign d_load = {1'b0, lfsr_q[3:0]} + 5'd1;
`else
    assign d_load = 5'(FIXED_DELAY);
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            out_q  <= 8'h00;
            go_q   <= 1'b0;
            busy_q <= 1'b0;
            rt_q   <= '0;
            tv_q   <= 1'b0;
            fs_q   <= 1'b0;
            hold_q <= '0;
            rcnt_q <= '0;
        end else begin
            state  <= state_nx;
            out_q  <= out_nx;
            go_q   <= go_nx;
            busy_q <= busy_nx;
            rt_q   <= rt_nx;
            tv_q   <= tv_nx;
            fs_q   <= fs_nx;
            hold_q <= hold_nx;
            rcnt_q <= rcnt_nx;
        end
    end

    // Next state and next output values; react outranks a same-cycle tick.
    always_comb begin
        state_nx = state;
        out_nx   = out_q;
        go_nx    = 1'b0;
        rt_nx    = rt_q;
        tv_nx    = 1'b0;
        fs_nx    = 1'b0;
        hold_nx  = hold_q;
        rcnt_nx  = rcnt_q;
        if (en) begin
            case (state)
                IDLE: begin
                    out_nx = 8'h00;
                    if (bus.start) begin
                        state_nx = LIGHTS;
                        out_nx   = 8'h01;
                    end
                end
                LIGHTS: begin
                    if (bus.react) begin
                        state_nx = IDLE;
                        out_nx   = 8'h00;
                        fs_nx    = 1'b1;
                    end else if (tick) begin
                        out_nx = {out_q[6:0], 1'b1};
                        if ({out_q[6:0], 1'b1} == LIGHTS_ALL) begin
                            state_nx = HOLD;
                            hold_nx  = d_load;
                        end
                    end
                end
                HOLD: begin
                    if (bus.react) begin
                        state_nx = IDLE;
                        out_nx   = 8'h00;
                        fs_nx    = 1'b1;
                    end else if (tick) begin
                        if (hold_q <= 5'd1) begin
                            state_nx = MEASURE;
                            out_nx   = 8'h00;
                            go_nx    = 1'b1;
                            hold_nx  = '0;
                            rcnt_nx  = '0;
                        end else begin
                            hold_nx = hold_q - 5'd1;
                        end
                    end
                end
                MEASURE: begin
                    if (bus.react) begin
                        state_nx = IDLE;
                        rt_nx    = rcnt_q;
                        tv_nx    = 1'b1;
                    end else if (rcnt_q != {RT_W{1'b1}}) begin
                        rcnt_nx = rcnt_q + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        busy_nx = (state_nx != IDLE);
    end

    assign bus.out           = out_q;
    assign bus.go            = go_q;
    assign bus.busy          = busy_q;
    assign bus.reaction_time = rt_q;
    assign bus.time_valid    = tv_q;
    assign bus.false_start   = fs_q;

endmodule

// File: doc/f1_start_sequencer.md
# f1_start_sequencer

Self-contained F1 start-light controller: paces an 8-light sequence from an internal tick generator and holds all lights for a delay. It then extinguishes the lights, asserts `go`, and measures the driver's reaction time in clock cycles. It replaces the free-running tick-plus-light-FSM pairing with one sequenced block that has start, false-start and timing control. The parent top level drives the lights output straight to the LED bar and `reaction_time` to the display.

## Interface
- `WIDTH`, 16, width of tick-period input `N`
- `FIXED_DELAY`, 3, hold delay in ticks when the random delay is compiled out (1..16)
- `clk` input 1: single clock, rising edge
- `rst` input 1: **one clock; reset is asynchronous and active-low**. All state clears while `rst`=0.
- `en` input 1: global enable. While 0, the tick counter, FSM, hold counter and reaction counter freeze, and `start`/`react` are ignored.
- `N` input WIDTH: tick period. A tick occurs every N+1 enabled cycles; N=0 gives a tick every cycle.
- `start` input 1: request a sequence; sampled only in IDLE.
- `react` input 1: driver response, level-sampled.
- `out` output 8: light bar
- `go` output 1: one-cycle pulse when the lights go out
- `busy` output 1: high in any state other than IDLE
- `reaction_time` output 16: last measured reaction, in cycles
- `time_valid` output 1: one-cycle pulse when `reaction_time` updates
- `false_start` output 1: one-cycle pulse when a false start is detected

## Operation
- Reset values:
  - `out`=8'h00, `go`=0, `busy`=0, `reaction_time`=16'h0000, `time_valid`=0, `false_start`=0
  - FSM in IDLE, tick counter 0, LFSR seed 7'h01
- **IDLE**: `out`=0. `start`=1 with `en`=1 moves to LIGHTS, sets `out`=8'h01 and clears the tick counter. If `start` and `react` arrive together, `start` wins and `react` is ignored.
- **LIGHTS**: on each tick, `out` becomes {out[6:0],1'b1}. The tick that moves 7F to FF also enters HOLD and loads the hold counter with D.
- **HOLD**: each tick decrements the hold counter. The tick that reaches 0 enters MEASURE, sets `out`=0, pulses `go`, and clears the reaction counter.
- **MEASURE**:
  - The reaction counter is 0 in the `go` cycle and increments every enabled cycle, saturating at 16'hFFFF.
  - `react`=1 with the counter at c loads `reaction_time`=c, pulses `time_valid`, and returns to IDLE.
  - `react` already high in the `go` cycle gives c=0.
- **False start**: `react`=1 in LIGHTS or HOLD sets `out`=0, pulses `false_start` and returns to IDLE. `reaction_time` is unchanged and `go` is not pulsed.
- `start` outside IDLE is ignored. `react` in IDLE is ignored.
- **Tick counter**: counts 0..N on enabled cycles and ticks at count==N, then wraps to 0. It only runs in LIGHTS/HOLD.
- **N changes**: a change to N mid-sequence takes effect at the next compare. If the count already exceeds the new N, the counter wraps at 2^WIDTH-1.
- **LFSR**: 7-bit Fibonacci, x^7+x^6+1. It advances every clock regardless of `en`, and is never zero.

## Timing
- All outputs are registered. `start` sampled at edge k gives `out`=01 from cycle k+1.
- Each subsequent light appears N+1 enabled cycles later, so FF appears at k+1+7(N+1).
- HOLD lasts D·(N+1) enabled cycles. `go` and `out`=0 appear in the cycle after the D-th hold tick.
- `time_valid` and `false_start` appear in the cycle after `react` is sampled. `busy` drops in that same cycle.
- **Reset mid-sequence**: `rst` low at any time returns everything to the reset values asynchronously. No pulse is emitted.

## Configuration
- `F1_RANDOM_DELAY_EN` defined: D = LFSR[3:0]+1 (range 1..16), sampled on the LIGHTS→HOLD transition.
- `F1_RANDOM_DELAY_EN` undefined: D = `FIXED_DELAY`, the LFSR is not instantiated, and behaviour is fully deterministic.

## Structure
- Package `f1_pkg`:
  - state enum {IDLE, LIGHTS, HOLD, MEASURE}
  - `LIGHTS_ALL`=8'hFF
  - `LFSR_W`=7, `LFSR_SEED`=7'h01, tap positions
  - `RT_W`=16
- Sub-module `f1_tick_gen` (`clk`, `rst`, `en`, `clr`, `N`, `tick`): the period counter with synchronous clear, on the same active-low asynchronous reset.

## Test plan
- Macro off, N=4, `start` at cycle 0 -> `out`=01@1, 03@6, 07@11 … FF@36; `go` pulse and `out`=00 @51; `busy` high 1..51+.
- After the `go` above, `react` high at cycle 51+20 -> `reaction_time`=20 and `time_valid`=1 one cycle later; `busy`=0.
- `react` pulsed while `out`=0F -> `false_start` pulse next cycle, `out`=00, no `go`, `reaction_time` unchanged.
- `en` held low for 10 cycles during LIGHTS -> `out` frozen; next light arrives 10 cycles late. A `start` pulse during the sequence is ignored.
- `rst`=0 during HOLD -> all outputs at reset values immediately. A `start` after release restarts from `out`=01.
- Macro on, N=0, 50 runs -> every hold length in 1..16 ticks, at least 8 distinct values, no lockup; no `react` -> counter saturates at FFFF.
